pipelined_addsub: RTL and testbench
===================================

Name: pipelined_addsub

Overview:
Parametrised, pipelined adder/subtractor that replaces the fixed 32-bit combinational adder wherever a registered, flag-producing add is needed. Targets are the multi-cycle/pipelined datapath, the branch-target path and the ALU add path. The carry chain is split into STAGES registered chunks, and a valid/ready handshake allows back-pressure. Each result carries carry, signed-overflow and zero flags.

Parameters:
WIDTH, 32, operand/result width in bits; must be divisible by STAGES.
STAGES, 2, pipeline depth and number of carry-chain chunks (1..4); chunk width CW = WIDTH/STAGES.

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operands presented this cycle
in_ready  output  1  block accepts operands this cycle
a  input  WIDTH  operand A (e.g. PC)
b  input  WIDTH  operand B (e.g. 4 or immediate)
sub  input  1  1 = compute a - b; 0 = compute a + b + cin
cin  input  1  carry-in for add; ignored when sub=1
out_valid  output  1  result/flags valid
out_ready  input  1  consumer accepts result this cycle
result  output  WIDTH  sum/difference, modulo 2^WIDTH
carry_out  output  1  carry out of MSB; for sub, 1 = no borrow (a >= b unsigned)
overflow  output  1  signed overflow of the operation
zero  output  1  result == 0

Behaviour:
- Reset (reset=1 at a clk edge): all stage valid bits, out_valid, result, carry_out, overflow and zero are cleared to 0. Any in-flight operations are discarded. in_ready = 1 in the first cycle after reset.
- Advance enable: adv = !(out_valid && !out_ready). in_ready = adv, combinational from out_valid/out_ready only, with no path from in_valid.
- Accept: the transfer occurs when in_valid && in_ready. Stage-0 valid ← in_valid when adv; if in_valid=0, a bubble enters.
- Operand preparation (stage 0): b' = sub ? ~b : b and c0 = sub ? 1 : cin. Stage 0 adds chunk 0 of a and b' with c0 and registers:
  - partial sum;
  - carry;
  - the remaining upper chunks of a and b';
  - MSB signs of a and b'.
- Stage k (1..STAGES-1): adds chunk k with the registered carry from stage k-1 and appends to the partial sum. Stages advance only when adv=1; when adv=0, every stage register holds.
- Latency: a result appears on out_valid exactly STAGES cycles after acceptance when unstalled. Throughput is one operation per cycle.
- Flags, registered with the final stage:
  - carry_out = carry from the MSB chunk;
  - overflow = (sign a == sign b') && (sign result != sign a);
  - zero = (result == 0).
- Output hold: while out_valid=1 and out_ready=0, result and flags hold stable and in_ready=0. Accepting new input requires out_ready=1 when out_valid=1 (a full pipeline passes through).
- Bubbles: out_valid=0 outputs may carry stale data and must not be consumed. The bench checks them only when out_valid=1.
- STAGES=1: single registered add, latency 1.
- Simultaneous reset and in_valid: reset wins, and the input is not accepted.
- Ordering: results exit strictly in acceptance order. No operation is dropped or duplicated under any out_ready pattern.

Test Plan:
- WIDTH=32/STAGES=2; a=0x00000100, b=0x4, sub=0, cin=0, out_ready=1 → 2 cycles later, out_valid=1, result=0x00000104, carry_out=0, overflow=0, zero=0.
- a=0x7FFFFFFF, b=0x1 add → result=0x80000000, overflow=1, carry_out=0; a=0xFFFFFFFF, b=0x1 add → result=0, carry_out=1, zero=1, overflow=0.
- Subtraction: a=5, b=5 → result=0, zero=1, carry_out=1; a=3, b=5 → result=0xFFFFFFFE, carry_out=0, overflow=0; a=0x80000000, b=1 → result=0x7FFFFFFF, overflow=1.
- Back-to-back stream of 8 ops, each a=i, b=0x10 → 8 consecutive out_valid cycles, in order, with results 0x10..0x17. Then hold out_ready=0 for 3 cycles mid-stream → in_ready=0, outputs stable, no loss or duplication after release.
- Assert reset for 1 cycle with 2 ops in flight → out_valid=0 next cycle, neither op ever emerges, and in_ready=1.
- Reparameterise WIDTH=16/STAGES=4 and WIDTH=32/STAGES=1 → latency 4 and 1 respectively; a=0x00FF, b=0x0001 (16-bit) → 0x0100 with the carry propagating across chunks. Compare against a randomised reference model over 10k ops with random out_ready.

Source files
------------

// File: rtl/pipelined_addsub.sv
// Pipelined adder/subtractor: the carry chain is cut into STAGES registered chunks,
// with a valid/ready handshake and carry/overflow/zero flags registered with the result.
module pipelined_addsub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic             zero
);

   localparam int CW = WIDTH / STAGES;
   localparam int L  = STAGES - 1;

   // Handshake: a transfer happens on an edge where valid && ready. The whole
   // pipeline moves together; it only freezes while a result sits unconsumed.
   logic adv;

   logic [STAGES-1:0] vld, s_c;
   logic [WIDTH-1:0]  s_sum [STAGES];
   logic [WIDTH-1:0]  s_a   [STAGES];
   logic [WIDTH-1:0]  s_b   [STAGES];

   logic [STAGES-1:0] src_v, src_c, n_c;
   logic [WIDTH-1:0]  src_sum [STAGES];
   logic [WIDTH-1:0]  src_a   [STAGES];
   logic [WIDTH-1:0]  src_b   [STAGES];
   logic [WIDTH-1:0]  n_sum   [STAGES];
   logic [CW:0]       part    [STAGES];

   logic ovf_q, zero_q, n_ovf, n_zero;

   assign adv      = !(out_valid && !out_ready);
   assign in_ready = adv;

   // Stage k's inputs: the ports for stage 0 (with b inverted for subtract), otherwise the previous stage registers.
   for (genvar k = 0; k < STAGES; k++) begin : g_src
      if (k == 0) begin : g_first
         assign src_v[k]   = in_valid;
         assign src_a[k]   = a;
         assign src_b[k]   = sub ? ~b : b;
         assign src_c[k]   = sub | cin;
         assign src_sum[k] = '0;
      end else begin : g_next
         assign src_v[k]   = vld[k-1];
         assign src_a[k]   = s_a[k-1];
         assign src_b[k]   = s_b[k-1];
         assign src_c[k]   = s_c[k-1];
         assign src_sum[k] = s_sum[k-1];
      end
   end

   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         part[k]  = {1'b0, src_a[k][k*CW +: CW]} + {1'b0, src_b[k][k*CW +: CW]}
                  + {{CW{1'b0}}, src_c[k]};
         n_c[k]   = part[k][CW];
         n_sum[k] = src_sum[k];
         n_sum[k][k*CW +: CW] = part[k][CW-1:0];
      end
   end

   assign n_zero = (n_sum[L] == '0);
   assign n_ovf  = (src_a[L][WIDTH-1] == src_b[L][WIDTH-1]) &&
                   (n_sum[L][WIDTH-1] != src_a[L][WIDTH-1]);

   always_ff @(posedge clk) begin
      if (reset) begin
         vld    <= '0;
         s_c    <= '0;
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            s_sum[k] <= '0;
            s_a[k]   <= '0;
            s_b[k]   <= '0;
         end
      end else if (adv) begin
         vld    <= src_v;
         s_c    <= n_c;
         ovf_q  <= n_ovf;
         zero_q <= n_zero;
         for (int k = 0; k < STAGES; k++) begin
            s_sum[k] <= n_sum[k];
            s_a[k]   <= src_a[k];
            s_b[k]   <= src_b[k];
         end
      end
   end

   assign out_valid = vld[L];
   assign result    = s_sum[L];
   assign carry_out = s_c[L];
   assign overflow  = ovf_q;
   assign zero      = zero_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed and random bench for pipelined_addsub: a 32/2 main instance with an
// expected-result queue, plus 16/4 and 32/1 instances for latency and chunk carries.
module tb_pipelined_addsub;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   // main instance, WIDTH=32 STAGES=2
   logic        in_valid, in_ready, sub, cin, out_valid, out_ready;
   logic        carry_out, overflow, zero;
   logic [31:0] a, b, result;

   pipelined_addsub #(.WIDTH(32), .STAGES(2)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sub(sub), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .carry_out(carry_out), .overflow(overflow), .zero(zero)
   );

   // WIDTH=16 STAGES=4
   logic        iv16, ir16, sub16, cin16, ov16, or16, c16, v16, z16;
   logic [15:0] a16, b16, r16;

   pipelined_addsub #(.WIDTH(16), .STAGES(4)) dut16 (
      .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16),
      .a(a16), .b(b16), .sub(sub16), .cin(cin16), .out_valid(ov16), .out_ready(or16),
      .result(r16), .carry_out(c16), .overflow(v16), .zero(z16)
   );

   // WIDTH=32 STAGES=1
   logic        iv1, ir1, sub1, cin1, ov1, or1, c1, v1, z1;
   logic [31:0] a1, b1, r1;

   pipelined_addsub #(.WIDTH(32), .STAGES(1)) dut1 (
      .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1),
      .a(a1), .b(b1), .sub(sub1), .cin(cin1), .out_valid(ov1), .out_ready(or1),
      .result(r1), .carry_out(c1), .overflow(v1), .zero(z1)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [34:0] exp_q[$];
   logic [34:0] cur_exp;

   function automatic logic [34:0] mk(input logic c, input logic v, input logic z,
                                       input logic [31:0] r);
      return {c, v, z, r};
   endfunction

   // independent reference: full-width add, flags from the definitions
   function automatic logic [34:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                          input logic ms, input logic mc);
      logic [31:0] bb;
      logic [32:0] s;
      bb = ms ? ~mb : mb;
      s  = {1'b0, ma} + {1'b0, bb} + {32'd0, (ms | mc)};
      return {s[32], (ma[31] == bb[31]) && (s[31] != ma[31]), (s[31:0] == 32'd0), s[31:0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: sample handshakes mid-cycle, score outputs, queue accepted inputs.
   task automatic cycle(output logic acc);
      logic [34:0] e;
      @(negedge clk);
      acc = in_valid && in_ready && !reset;
      if (!reset && out_valid && out_ready) begin
         n_checks++;
         assert (exp_q.size() != 0) else begin
            n_fail++;
            $error("FAIL out_spurious: observed output %h, expected none", result);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("out_data", {carry_out, overflow, zero, result}, e);
         end
      end
      if (acc) exp_q.push_back(cur_exp);
      @(posedge clk);
      #1;
   endtask

   task automatic go(input logic [31:0] ta, input logic [31:0] tb_, input logic ts,
                     input logic tc, input logic [34:0] e);
      logic acc;
      int   tries;
      tries = 0;
      a = ta; b = tb_; sub = ts; cin = tc; cur_exp = e; in_valid = 1'b1;
      do begin
         cycle(acc);
         tries++;
      end while (!acc && tries < 50);
      chk("go_accept", acc, 1);
      in_valid = 1'b0;
   endtask

   task automatic drain(input int n, input string tag);
      logic acc;
      in_valid = 1'b0;
      repeat (n) cycle(acc);
      chk(tag, exp_q.size(), 0);
   endtask

   task automatic small_test(input bit which, input logic [31:0] ta, input logic [31:0] tb_,
                             input logic ts, input logic [34:0] e, input int elat);
      int          lat;
      logic [34:0] got;
      chk(which ? "s1_in_ready" : "s4_in_ready", which ? ir1 : ir16, 1);
      if (which) begin a1 = ta; b1 = tb_; sub1 = ts; iv1 = 1'b1; end
      else begin a16 = ta[15:0]; b16 = tb_[15:0]; sub16 = ts; iv16 = 1'b1; end
      @(posedge clk); #1;
      iv1 = 1'b0; iv16 = 1'b0;
      lat = 1;
      while (!(which ? ov1 : ov16) && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      got = which ? {c1, v1, z1, r1} : {c16, v16, z16, 16'h0, r16};
      chk(which ? "s1_latency" : "s4_latency", lat, elat);
      chk(which ? "s1_result" : "s4_result", got, e);
      @(posedge clk); #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: observed no finish, expected finish before 2000000");
      $fatal(1, "watchdog");
   end

   initial begin
      logic        acc;
      logic [34:0] held;
      logic [31:0] ra, rb;
      int          issued, cyc;

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      a = '0; b = '0; sub = 1'b0; cin = 1'b0; cur_exp = '0;
      iv16 = 1'b0; a16 = '0; b16 = '0; sub16 = 1'b0; cin16 = 1'b0; or16 = 1'b1;
      iv1 = 1'b0; a1 = '0; b1 = '0; sub1 = 1'b0; cin1 = 1'b0; or1 = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // reset state
      chk("rst_out_valid", out_valid, 0);
      chk("rst_flags_result", {carry_out, overflow, zero, result}, 0);
      chk("rst_in_ready", in_ready, 1);

      // latency of one op through an empty pipeline
      go(32'h0000_0100, 32'h4, 1'b0, 1'b0, mk(0, 0, 0, 32'h0000_0104));
      chk("lat_ov_edge1", out_valid, 0);
      cycle(acc);
      chk("lat_ov_edge2", out_valid, 1);
      chk("lat_result", result, 32'h0000_0104);
      drain(3, "lat_drain");

      // directed vectors, back to back
      go(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, mk(0, 1, 0, 32'h8000_0000));
      go(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, mk(1, 0, 1, 32'h0000_0000));
      go(32'h0000_0005, 32'h5, 1'b1, 1'b0, mk(1, 0, 1, 32'h0000_0000));
      go(32'h0000_0003, 32'h5, 1'b1, 1'b0, mk(0, 0, 0, 32'hFFFF_FFFE));
      go(32'h8000_0000, 32'h1, 1'b1, 1'b0, mk(1, 1, 0, 32'h7FFF_FFFF));
      go(32'h0000_0001, 32'h2, 1'b0, 1'b1, mk(0, 0, 0, 32'h0000_0004));
      go(32'h0000_0007, 32'h2, 1'b1, 1'b1, mk(1, 0, 0, 32'h0000_0005));
      go(32'h0000_FFFF, 32'h1, 1'b0, 1'b0, mk(0, 0, 0, 32'h0001_0000));
      drain(4, "vec_drain");

      // 8-op stream: outputs must appear on consecutive cycles, in order
      for (int i = 0; i < 8; i++) begin
         go(i, 32'h10, 1'b0, 1'b0, mk(0, 0, 0, 32'h10 + i));
         chk("stream_ov", out_valid, (i + 1 >= 2));
      end
      cycle(acc);
      chk("stream_ov_tail", out_valid, 1);
      drain(3, "stream_drain");

      // stall for 3 cycles with a full pipeline
      for (int i = 0; i < 3; i++) go(32'h100 + i, 32'h10, 1'b0, 1'b0, mk(0, 0, 0, 32'h110 + i));
      a = 32'h103; b = 32'h10; sub = 1'b0; cin = 1'b0; cur_exp = mk(0, 0, 0, 32'h113);
      in_valid = 1'b1; out_ready = 1'b0;
      #1;
      chk("stall_in_ready_now", in_ready, 0);
      held = {carry_out, overflow, zero, result};
      for (int i = 0; i < 3; i++) begin
         cycle(acc);
         chk("stall_in_ready", in_ready, 0);
         chk("stall_out_valid", out_valid, 1);
         chk("stall_hold", {carry_out, overflow, zero, result}, held);
      end
      out_ready = 1'b1;
      cyc = 0;
      do begin cycle(acc); cyc++; end while (!acc && cyc < 10);
      chk("stall_release_accept", acc, 1);
      in_valid = 1'b0;
      for (int i = 4; i < 6; i++) go(32'h100 + i, 32'h10, 1'b0, 1'b0, mk(0, 0, 0, 32'h110 + i));
      drain(4, "stall_drain");

      // reset with two ops in flight and a simultaneous in_valid
      go(32'h1111, 32'h1, 1'b0, 1'b0, mk(0, 0, 0, 32'h1112));
      go(32'h2222, 32'h2, 1'b0, 1'b0, mk(0, 0, 0, 32'h2224));
      out_ready = 1'b0; reset = 1'b1;
      a = 32'h3333; b = 32'h3; cur_exp = mk(0, 0, 0, 32'h3336); in_valid = 1'b1;
      cycle(acc);
      reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      exp_q.delete();
      chk("rst_flight_ov", out_valid, 0);
      chk("rst_flight_in_ready", in_ready, 1);
      for (int i = 0; i < 5; i++) begin
         cycle(acc);
         chk("rst_flight_gone", out_valid, 0);
      end

      // random operands with random back-pressure against the reference model
      issued = 0; cyc = 0; in_valid = 1'b0;
      while (issued < 10000 && cyc < 40000) begin
         if (!in_valid && $urandom_range(0, 3) != 0) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
            a = ra; b = rb; sub = $urandom_range(0, 1); cin = $urandom_range(0, 1);
            cur_exp = model(ra, rb, sub, cin);
            in_valid = 1'b1;
         end
         out_ready = ($urandom_range(0, 9) < 7);
         cycle(acc);
         cyc++;
         if (acc) begin
            issued++;
            in_valid = 1'b0;
         end
      end
      chk("rand_issued", issued, 10000);
      out_ready = 1'b1;
      drain(6, "rand_drain");

      // other parameterisations
      small_test(1'b0, 32'h00FF, 32'h0001, 1'b0, mk(0, 0, 0, 32'h0100), 4);
      small_test(1'b0, 32'hFFFF, 32'h0001, 1'b0, mk(1, 0, 1, 32'h0000), 4);
      small_test(1'b0, 32'h8000, 32'h0001, 1'b1, mk(1, 1, 0, 32'h7FFF), 4);
      small_test(1'b1, 32'h0000_0100, 32'h4, 1'b0, mk(0, 0, 0, 32'h0000_0104), 1);
      small_test(1'b1, 32'hFFFF_FFFF, 32'h1, 1'b0, mk(1, 0, 1, 32'h0000_0000), 1);
      small_test(1'b1, 32'h0000_0003, 32'h5, 1'b1, mk(0, 0, 0, 32'hFFFF_FFFE), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
